// File: rtl/switch_input_conditioner.sv
// Switch/button front end: synchronizes, debounces and registers two switch banks
// and a toggle-select button, pulsing `changed` whenever any registered output moves.
module switch_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_x,
    input  logic [WIDTH-1:0] sw_y,
    input  logic             btn_sel,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             s,
    output logic             changed
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    logic [WIDTH-1:0] meta_x, meta_y, sync_x, sync_y;
    logic             meta_btn, sync_btn;

    // NOTE: every flop uses <= so all stages sample the pre-edge values; a blocking
    // assignment here would collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_x   <= '0;
            meta_y   <= '0;
            meta_btn <= 1'b0;
            sync_x   <= '0;
            sync_y   <= '0;
            sync_btn <= 1'b0;
        end else begin
            meta_x   <= sw_x;
            meta_y   <= sw_y;
            meta_btn <= btn_sel;
            sync_x   <= meta_x;
            sync_y   <= meta_y;
            sync_btn <= meta_btn;
        end
    end

    // Bank 0 is X, bank 1 is Y; any mismatch with the candidate restarts its count.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [WIDTH-1:0] sync_v;
        logic [WIDTH-1:0] cand;
        logic [WIDTH-1:0] out_q;
        logic [CNT_W-1:0] cnt;
        logic             upd;

        assign sync_v = (b == 0) ? sync_x : sync_y;
        assign upd    = (sync_v == cand) && (cnt == CNT_MAX) && (cand != out_q);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand  <= '0;
                cnt   <= '0;
                out_q <= '0;
            end else if (sync_v != cand) begin
                cand <= sync_v;
                cnt  <= CNT_ONE;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                if (upd) out_q <= cand;
            end
        end
    end

    assign x = g_bank[0].out_q;
    assign y = g_bank[1].out_q;

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] btn_cnt, btn_cnt_nxt;
    logic             s_upd;

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        btn_cnt_nxt = btn_cnt;
        s_upd       = 1'b0;
        unique case (state)
            RELEASED: begin
                if (sync_btn) begin
                    state_nxt   = PRESS_WAIT;
                    btn_cnt_nxt = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync_btn) begin
                    state_nxt = RELEASED;
                end else if (btn_cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    s_upd     = 1'b1;
                end else begin
                    btn_cnt_nxt = btn_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync_btn) begin
                    state_nxt   = RELEASE_WAIT;
                    btn_cnt_nxt = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync_btn) begin
                    state_nxt = PRESSED;
                end else if (btn_cnt == CNT_MAX) begin
                    state_nxt = RELEASED;
                end else begin
                    btn_cnt_nxt = btn_cnt + CNT_ONE;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RELEASED;
            btn_cnt <= '0;
            s       <= 1'b0;
            changed <= 1'b0;
        end else begin
            state   <= state_nxt;
            btn_cnt <= btn_cnt_nxt;
            if (s_upd) s <= ~s;
            changed <= g_bank[0].upd | g_bank[1].upd | s_upd;
        end
    end

endmodule
